// File: rtl/calc_core.sv
// calc_core: BCD operand entry with add/sub/mul/div, restoring divider and double-dabble output stage.
// Define CALC_DIV_ROUND_EN for round-half-up division; when it is undefined, division truncates.
module calc_core #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [DIGITS-1:0]   inc_a,
  input  logic [DIGITS-1:0]   inc_b,
  input  logic                start,
  input  logic [1:0]          op,
  output logic [4*DIGITS-1:0] opa_bcd,
  output logic [4*DIGITS-1:0] opb_bcd,
  output logic [8*DIGITS-1:0] res_bcd,
  output logic                neg,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int OP_W  = $clog2(10**DIGITS);
  localparam int RES_W = $clog2(10**(2*DIGITS));
`ifdef CALC_DIV_ROUND_EN
  localparam int DV_W  = OP_W + 2;
`else
  localparam int DV_W  = OP_W;
`endif
  localparam int CNT_W = $clog2(RES_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_CONV} state_t;

  state_t                       r_state;
  state_t                       w_state_nx;
  logic [DIGITS-1:0][3:0]       r_a_dig;
  logic [DIGITS-1:0][3:0]       r_b_dig;
  logic [1:0]                   r_op;
  logic [OP_W-1:0]              r_a_bin;
  logic [OP_W-1:0]              r_b_bin;
  logic [RES_W-1:0]             r_bin;
  logic [8*DIGITS-1:0]          r_bcd;
  logic [DV_W-1:0]              r_dvd;
  logic [DV_W-1:0]              r_dvs;
  logic [DV_W-1:0]              r_rem;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_neg_nxt;
  logic [8*DIGITS-1:0]          r_res;
  logic                         r_neg;
  logic                         r_err;
  logic                         r_done;

  logic                         w_busy;
  logic                         w_cnt_last;
  logic                         w_div0;
  logic                         w_a_lt_b;
  logic [RES_W-1:0]             w_sum;
  logic [RES_W-1:0]             w_diff;
  logic [RES_W-1:0]             w_prod;
  logic [DV_W:0]                w_rem_sh;
  logic                         w_q_bit;
  logic [DV_W:0]                w_rem_nx;
  logic [DV_W-1:0]              w_quo;
  logic [8*DIGITS-1:0]          w_bcd_adj;
  logic [8*DIGITS-1:0]          w_bcd_nx;

  function automatic logic [OP_W-1:0] bcd2bin(input logic [DIGITS-1:0][3:0] d);
    logic [OP_W-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = OP_W'(acc * OP_W'(10)) + OP_W'(d[i]);
    end
    return acc;
  endfunction

  assign w_busy     = (r_state != S_IDLE);
  assign w_cnt_last = (r_cnt == '0);
  assign w_div0     = (r_b_bin == '0);
  assign w_a_lt_b   = (r_a_bin < r_b_bin);

  assign w_sum  = RES_W'(r_a_bin) + RES_W'(r_b_bin);
  assign w_diff = w_a_lt_b ? RES_W'(r_b_bin - r_a_bin) : RES_W'(r_a_bin - r_b_bin);
  assign w_prod = RES_W'(r_a_bin) * RES_W'(r_b_bin);

  // Restoring division: remainder never exceeds the divisor, so DV_W bits hold it after the subtract.
  assign w_rem_sh = {r_rem, r_dvd[DV_W-1]};
  assign w_q_bit  = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_q_bit ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
  assign w_quo    = {r_dvd[DV_W-2:0], w_q_bit};

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 2 * DIGITS; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_nx = {w_bcd_adj[8*DIGITS-2:0], r_bin[RES_W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nx = S_EXEC;
      S_EXEC: begin
        if (r_op == 2'b11) begin
          w_state_nx = w_div0 ? S_IDLE : S_DIV;
        end else begin
          w_state_nx = S_CONV;
        end
      end
      S_DIV:  if (w_cnt_last) w_state_nx = S_CONV;
      S_CONV: if (w_cnt_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand entry is frozen for the whole operation so the displayed operands match the latched ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_dig <= '0;
      r_b_dig <= '0;
    end else if (!w_busy) begin
      if (clr) begin
        r_a_dig <= '0;
        r_b_dig <= '0;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (inc_a[i]) r_a_dig[i] <= (r_a_dig[i] == 4'd9) ? 4'd0 : r_a_dig[i] + 4'd1;
          if (inc_b[i]) r_b_dig[i] <= (r_b_dig[i] == 4'd9) ? 4'd0 : r_b_dig[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_a_bin   <= '0;
      r_b_bin   <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_neg_nxt <= 1'b0;
      r_res     <= '0;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a_bin <= bcd2bin(r_a_dig);
            r_b_bin <= bcd2bin(r_b_dig);
          end
        end
        S_EXEC: begin
          r_neg_nxt <= 1'b0;
          r_bcd     <= '0;
          r_cnt     <= CNT_W'(RES_W - 1);
          case (r_op)
            2'b00: r_bin <= w_sum;
            2'b01: begin
              r_bin     <= w_diff;
              r_neg_nxt <= w_a_lt_b;
            end
            2'b10: r_bin <= w_prod;
            default: begin
              if (w_div0) begin
                r_err  <= 1'b1;
                r_neg  <= 1'b0;
                r_done <= 1'b1;
              end else begin
`ifdef CALC_DIV_ROUND_EN
                // (2A+B)/(2B) == floor(A/B + 1/2)
                r_dvd <= DV_W'({r_a_bin, 1'b0}) + DV_W'(r_b_bin);
                r_dvs <= DV_W'({r_b_bin, 1'b0});
`else
                r_dvd <= DV_W'(r_a_bin);
                r_dvs <= DV_W'(r_b_bin);
`endif
                r_rem <= '0;
                r_cnt <= CNT_W'(DV_W - 1);
              end
            end
          endcase
        end
        S_DIV: begin
          r_dvd <= w_quo;
          r_rem <= w_rem_nx[DV_W-1:0];
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_cnt_last) begin
            r_bin <= RES_W'(w_quo);
            r_bcd <= '0;
            r_cnt <= CNT_W'(RES_W - 1);
          end
        end
        S_CONV: begin
          r_bin <= {r_bin[RES_W-2:0], 1'b0};
          r_bcd <= w_bcd_nx;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_cnt_last) begin
            r_res  <= w_bcd_nx;
            r_neg  <= r_neg_nxt;
            r_err  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign opa_bcd = r_a_dig;
  assign opb_bcd = r_b_dig;
  assign res_bcd = r_res;
  assign neg     = r_neg;
  assign err     = r_err;
  assign busy    = w_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core at DIGITS=2; expected results are queued at start and popped on done.
module tb_calc_core;
  localparam int DIGITS = 2;
`ifdef CALC_DIV_ROUND_EN
  localparam int DIV_LAT = 25;
`else
  localparam int DIV_LAT = 23;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [1:0]  inc_a;
  logic [1:0]  inc_b;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  opa_bcd;
  logic [7:0]  opb_bcd;
  logic [15:0] res_bcd;
  logic        neg;
  logic        err;
  logic        busy;
  logic        done;

  calc_core #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .inc_a(inc_a), .inc_b(inc_b),
    .start(start), .op(op), .opa_bcd(opa_bcd), .opb_bcd(opb_bcd),
    .res_bcd(res_bcd), .neg(neg), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        neg;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] last_res = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic enter(input int a, input int b);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int n = 0; n < 9; n++) begin
      inc_a[0] = (n < a % 10);
      inc_a[1] = (n < a / 10);
      inc_b[0] = (n < b % 10);
      inc_b[1] = (n < b / 10);
      @(negedge clk);
    end
    inc_a = '0;
    inc_b = '0;
    check("opa_entry", 32'(opa_bcd), 32'(to_bcd(a)));
    check("opb_entry", 32'(opb_bcd), 32'(to_bcd(b)));
  endtask

  task automatic run_op(input logic [1:0] o, input int a, input int b, input bit disturb);
    exp_t e;
    int   q;
    int   lat;
    int   extra;
    e.neg = 1'b0;
    e.err = 1'b0;
    e.lat = 16;
    case (o)
      2'b00: q = a + b;
      2'b01: begin
        q = (a < b) ? b - a : a - b;
        e.neg = (a < b);
      end
      2'b10: q = a * b;
      default: begin
        if (b == 0) begin
          q = -1;
          e.err = 1'b1;
          e.lat = 2;
        end else begin
          q = a / b;
`ifdef CALC_DIV_ROUND_EN
          if (2 * (a % b) >= b) q = q + 1;
`endif
          e.lat = DIV_LAT;
        end
      end
    endcase
    e.res = (q < 0) ? last_res : to_bcd(q);
    sb.push_back(e);

    start = 1'b1;
    op    = o;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_rise", 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      if (lat == 2) check("res_hold", 32'(res_bcd), 32'(last_res));
      if (disturb && lat == 3) begin
        start = 1'b1;
        op    = ~o;
        inc_a = '1;
        clr   = 1'b1;
      end
      if (disturb && lat == 4) begin
        start = 1'b0;
        inc_a = '0;
        clr   = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("done_lat", 32'(lat), 32'(e.lat));
    check("res_bcd", 32'(res_bcd), 32'(e.res));
    check("neg", 32'(neg), 32'(e.neg));
    check("err", 32'(err), 32'(e.err));
    check("busy_fall", 32'(busy), 32'd0);
    last_res = e.res;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    if (disturb) begin
      check("opa_frozen", 32'(opa_bcd), 32'(to_bcd(a)));
      check("opb_frozen", 32'(opb_bcd), 32'(to_bcd(b)));
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        if (done || busy) extra++;
        @(negedge clk);
      end
      check("no_queued_start", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    clr   = 1'b0;
    inc_a = '0;
    inc_b = '0;
    start = 1'b0;
    op    = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_res", 32'(res_bcd), 32'd0);
    check("rst_flags", 32'({neg, err, busy, done}), 32'd0);
    check("rst_opa", 32'(opa_bcd), 32'd0);
    check("rst_opb", 32'(opb_bcd), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Digit wrap with simultaneous pulses
    enter(9, 0);
    inc_a = 2'b11;
    @(negedge clk);
    inc_a = '0;
    check("wrap_10", 32'(opa_bcd), 32'h10);
    for (int i = 0; i < 9; i++) begin
      inc_a = 2'b10;
      @(negedge clk);
    end
    inc_a = '0;
    check("wrap_00", 32'(opa_bcd), 32'h00);

    // clr beats inc in the same cycle
    enter(35, 53);
    clr   = 1'b1;
    inc_a = 2'b01;
    inc_b = 2'b11;
    @(negedge clk);
    clr   = 1'b0;
    inc_a = '0;
    inc_b = '0;
    check("clr_wins_a", 32'(opa_bcd), 32'd0);
    check("clr_wins_b", 32'(opb_bcd), 32'd0);

    enter(99, 99);
    run_op(2'b00, 99, 99, 1'b0);
    enter(12, 0);
    run_op(2'b11, 12, 0, 1'b0);
    enter(12, 45);
    run_op(2'b01, 12, 45, 1'b0);
    enter(99, 99);
    run_op(2'b10, 99, 99, 1'b1);
    enter(7, 2);
    run_op(2'b11, 7, 2, 1'b0);
    enter(50, 4);
    run_op(2'b11, 50, 4, 1'b0);
    enter(45, 7);
    run_op(2'b00, 45, 7, 1'b0);
    enter(0, 0);
    run_op(2'b01, 0, 0, 1'b0);

    // Reset in the middle of a divide
    enter(7, 2);
    start = 1'b1;
    op    = 2'b11;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mid_div_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_res", 32'(res_bcd), 32'd0);
    check("mrst_flags", 32'({neg, err, busy, done}), 32'd0);
    check("mrst_opa", 32'(opa_bcd), 32'd0);
    rst = 1'b1;
    last_res = 16'h0000;
    @(negedge clk);
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
        if (done || busy) stray++;
        @(negedge clk);
      end
      check("mrst_idle", 32'(stray), 32'd0);
    end
    enter(7, 2);
    run_op(2'b11, 7, 2, 1'b0);
    enter(99, 1);
    run_op(2'b01, 99, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_core.md
# calc_core

Parametrised arithmetic core for the push-button calculator: holds two BCD operands entered by per-digit increment pulses, runs add/subtract/multiply/divide on a start handshake, and returns a sign-magnitude BCD result. It sits between the per-button synchronizer/debouncer/edge stages and the seven-segment scan driver. It generalises the two-digit calculator to `DIGITS` digits per operand, with a multi-cycle divider, a sequential binary-to-BCD converter and a busy/done handshake.

## Interface
- `DIGITS`, 2, BCD digits per operand; the result has `2*DIGITS` digits.
- Derived, not overridable:
  - `OP_W`: bits for 10^DIGITS−1 (7 at default).
  - `RES_W`: bits for 10^(2·DIGITS)−1 (14 at default).
  - `DV_W`: `OP_W+2` with rounding, `OP_W` without.
- `clk  in  1`: single clock, all logic on rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `clr  in  1`: synchronous clear of both operands; ignored while busy.
- `inc_a  in  DIGITS`: one-cycle pulses; bit i increments digit i of operand A.
- `inc_b  in  DIGITS`: same, for operand B.
- `start  in  1`: one-cycle request; accepted only when `busy`=0.
- `op  in  2`: 00 add (A+B), 01 sub (A−B), 10 mul (A·B), 11 div (A/B); sampled with `start`.
- `opa_bcd  out  4*DIGITS`: operand A digits, digit 0 in the LSBs.
- `opb_bcd  out  4*DIGITS`: operand B digits, digit 0 in the LSBs.
- `res_bcd  out  8*DIGITS`: result magnitude in BCD.
- `neg  out  1`: result is negative.
- `err  out  1`: division by zero.
- `busy  out  1`: operation in progress.
- `done  out  1`: one-cycle completion pulse.

## Operation
- Reset (`rst`=0) forces all outputs and operands to 0 and the FSM to IDLE. It is honoured mid-operation; any partial result is discarded.
- Operand entry:
  - Each inc pulse steps its digit 0→1→…→9→0.
  - All simultaneous pulses are applied in the same cycle; there is no priority between them.
  - `clr` and an inc pulse in the same cycle: `clr` wins.
  - Entry and `clr` are ignored while `busy`=1.
- FSM states: IDLE, EXEC, DIV, CONV.
- IDLE:
  - `start`=1 latches `op` and the binary values of both operands (Σ digit·10^i), then moves to EXEC.
  - `start` while busy is dropped, not queued.
- EXEC (1 cycle):
  - Add: bin = A+B.
  - Sub: bin = |A−B|, neg_next = (A<B).
  - Mul: bin = A·B in `RES_W` bits; no overflow is possible.
  - Div with B=0: set `err`=1, clear `neg`, keep `res_bcd` unchanged, pulse `done` and return to IDLE. CONV is skipped.
  - Div with B≠0: load the dividend and go to DIV.
- DIV: restoring shift-subtract, one quotient bit per cycle for `DV_W` cycles, then CONV.
- CONV: shift-add-3 (double dabble), one bit per cycle for `RES_W` cycles.
- Completion (after the last CONV cycle):
  - `res_bcd`, `neg` and `err` (cleared to 0) update.
  - `done`=1 for one cycle, `busy`=0, FSM returns to IDLE.
- For non-error operations `res_bcd`, `neg` and `err` change only at completion; they hold between operations.

## Timing
- `start` sampled at edge k; `busy`=1 from k+1.
- Add, sub, mul: `done` and the new result at edge k+RES_W+2 (k+16 at default).
- Div: `done` at edge k+DV_W+RES_W+2 (k+25 at default with rounding, k+23 without).
- Div by zero: `done` and `err` at edge k+2.
- `busy` falls in the same cycle `done` is high. The earliest next accepted `start` is in that cycle.
- Operand outputs are registered and update on the edge after an inc pulse.

## Configuration
- `CALC_DIV_ROUND_EN` defined: divide returns round-half-up. Dividend 2A+B, divisor 2B, `DV_W`=`OP_W`+2.
- `CALC_DIV_ROUND_EN` undefined: divide truncates. Dividend A, divisor B, `DV_W`=`OP_W`.
- Mul, add, sub and the div-by-zero path are identical in both builds.

## Test plan
All cases at `DIGITS`=2.
- Digit wrap: A=09, pulse `inc_a`=2'b11 once → A=10. Pulse bit 1 nine times → A=00.
- Add: A=99, B=99, op=00, start at k → `res_bcd`=0198, `neg`=0, `done` only at k+16, `busy` high k+1..k+15.
- Sub: A=12, B=45, op=01 → `res_bcd`=0033, `neg`=1. Then op=10 with A=99, B=99 → 9801, `neg`=0.
- Divide, A=07, B=02, op=11:
  - Rounding build: 0004, `done` at k+25.
  - Truncating build: 0003, `done` at k+23.
- Div by zero: prior result 0198, B=00, op=11 → `err`=1 at k+2, `res_bcd` stays 0198. A following add clears `err`.
- Robustness:
  - Second `start` and `inc_a` pulses during busy → ignored.
  - `rst` low mid-DIV → all outputs 0, FSM IDLE.
  - `start` after release → normal completion.
